// File: rtl/ram_req_arbiter.sv
// Shares one single-port RAM between a write and a read requester, with a response FIFO on reads.
// Define RAM_ARB_WR_PRIO_EN for fixed write priority; round-robin otherwise.
module ram_req_arbiter #(
    parameter int unsigned DATA_WD    = 128,
    parameter int unsigned ADDR_WD    = 32,
    parameter int unsigned STRB_WD    = DATA_WD / 8,
    parameter int unsigned RESP_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wreq_valid,
    output logic               wreq_ready,
    input  logic [ADDR_WD-1:0] wreq_addr,
    input  logic [DATA_WD-1:0] wreq_data,
    input  logic [STRB_WD-1:0] wreq_strb,
    input  logic               rreq_valid,
    output logic               rreq_ready,
    input  logic [ADDR_WD-1:0] rreq_addr,
    output logic               rresp_valid,
    input  logic               rresp_ready,
    output logic [DATA_WD-1:0] rresp_data,
    output logic               ram_wr_en,
    output logic               ram_rd_en,
    output logic [ADDR_WD-1:0] ram_addr,
    output logic [STRB_WD-1:0] ram_strobe,
    output logic [DATA_WD-1:0] ram_w_data,
    input  logic [DATA_WD-1:0] ram_r_data
);

    localparam int unsigned OFFS   = $clog2(STRB_WD);
    localparam int unsigned PTR_WD = $clog2(RESP_DEPTH);
    localparam logic [PTR_WD:0] DEPTH_CNT = (PTR_WD + 1)'(RESP_DEPTH);

    logic [PTR_WD:0]    count_q;
    logic [PTR_WD-1:0]  wr_ptr_q;
    logic [PTR_WD-1:0]  rd_ptr_q;
    logic               rd_inflight_q;
    logic [DATA_WD-1:0] fifo_mem [RESP_DEPTH];

    logic rd_elig;
    logic grant_wr;
    logic grant_rd;
    logic push;
    logic pop;

    // Slots already owed to in-flight reads count as occupied; a same-cycle pop is not credited.
    assign rd_elig = ({1'b0, count_q} + {{(PTR_WD + 1){1'b0}}, rd_inflight_q})
                     < {1'b0, DEPTH_CNT};

`ifdef RAM_ARB_WR_PRIO_EN
    always_comb begin
        grant_wr = wreq_valid;
        grant_rd = !wreq_valid && rreq_valid && rd_elig;
    end
`else
    logic last_wr_q;  // 1 when the most recent grant went to the write side

    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (wreq_valid && rreq_valid && rd_elig) begin
            if (last_wr_q) grant_rd = 1'b1;
            else           grant_wr = 1'b1;
        end else if (wreq_valid) begin
            grant_wr = 1'b1;
        end else if (rreq_valid && rd_elig) begin
            grant_rd = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_wr_q <= 1'b1;
        end else if (grant_wr || grant_rd) begin
            last_wr_q <= grant_wr;
        end
    end
`endif

    // Outputs are forced quiet while reset is asserted, even if requesters keep valid high.
    assign wreq_ready = grant_wr && rst_n;
    assign rreq_ready = grant_rd && rst_n;

    always_comb begin
        ram_wr_en  = 1'b0;
        ram_rd_en  = 1'b0;
        ram_addr   = '0;
        ram_strobe = '0;
        ram_w_data = '0;
        if (rst_n) begin
            if (grant_wr) begin
                ram_wr_en  = 1'b1;
                ram_addr   = wreq_addr >> OFFS;
                ram_strobe = wreq_strb;
                ram_w_data = wreq_data;
            end else if (grant_rd) begin
                ram_rd_en = 1'b1;
                ram_addr  = rreq_addr >> OFFS;
            end
        end
    end

    assign push        = rd_inflight_q;
    assign rresp_valid = (count_q != '0);
    assign pop         = rresp_valid && rresp_ready;
    assign rresp_data  = fifo_mem[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_inflight_q <= 1'b0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            rd_inflight_q <= grant_rd;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= ram_r_data;
    end

`ifndef SYNTHESIS
    no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && count_q == DEPTH_CNT));
`endif

endmodule

// File: tb/tb_ram_req_arbiter.sv
// Self-checking bench for ram_req_arbiter: behavioural RAM, shadow memory and response scoreboard.
module tb_ram_req_arbiter;

    localparam int DW = 128;
    localparam int AW = 32;
    localparam int SW = 16;

    logic          clk;
    logic          rst_n;
    logic          wreq_valid;
    logic          wreq_ready;
    logic [AW-1:0] wreq_addr;
    logic [DW-1:0] wreq_data;
    logic [SW-1:0] wreq_strb;
    logic          rreq_valid;
    logic          rreq_ready;
    logic [AW-1:0] rreq_addr;
    logic          rresp_valid;
    logic          rresp_ready;
    logic [DW-1:0] rresp_data;
    logic          ram_wr_en;
    logic          ram_rd_en;
    logic [AW-1:0] ram_addr;
    logic [SW-1:0] ram_strobe;
    logic [DW-1:0] ram_w_data;
    logic [DW-1:0] ram_r_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] sb_q [$];
    logic [DW-1:0] shadow  [64];
    logic [DW-1:0] ram_mem [64];

    ram_req_arbiter #(
        .DATA_WD   (DW),
        .ADDR_WD   (AW),
        .STRB_WD   (SW),
        .RESP_DEPTH(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wreq_valid (wreq_valid),
        .wreq_ready (wreq_ready),
        .wreq_addr  (wreq_addr),
        .wreq_data  (wreq_data),
        .wreq_strb  (wreq_strb),
        .rreq_valid (rreq_valid),
        .rreq_ready (rreq_ready),
        .rreq_addr  (rreq_addr),
        .rresp_valid(rresp_valid),
        .rresp_ready(rresp_ready),
        .rresp_data (rresp_data),
        .ram_wr_en  (ram_wr_en),
        .ram_rd_en  (ram_rd_en),
        .ram_addr   (ram_addr),
        .ram_strobe (ram_strobe),
        .ram_w_data (ram_w_data),
        .ram_r_data (ram_r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural single-port RAM with one cycle of read latency.
    always @(posedge clk) begin : ram_model
        logic [DW-1:0] w;
        if (ram_wr_en) begin
            w = ram_mem[ram_addr[5:0]];
            for (int b = 0; b < SW; b++)
                if (ram_strobe[b]) w[b*8 +: 8] = ram_w_data[b*8 +: 8];
            ram_mem[ram_addr[5:0]] <= w;
        end
        if (ram_rd_en) ram_r_data <= ram_mem[ram_addr[5:0]];
    end

    // Handshake monitor: checks RAM drive, updates shadow memory, feeds and drains the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wreq_valid && wreq_ready) begin
                check("wr_en", ram_wr_en, 1);
                check("wr_rd_en", ram_rd_en, 0);
                check("wr_addr", ram_addr, wreq_addr >> 4);
                check("wr_strb", ram_strobe, wreq_strb);
                check("wr_data", ram_w_data, wreq_data);
                check("wr_rd_excl", rreq_ready, 0);
                for (int b = 0; b < SW; b++)
                    if (wreq_strb[b]) shadow[wreq_addr[9:4]][b*8 +: 8] = wreq_data[b*8 +: 8];
            end else if (rreq_valid && rreq_ready) begin
                check("rd_en", ram_rd_en, 1);
                check("rd_wr_en", ram_wr_en, 0);
                check("rd_addr", ram_addr, rreq_addr >> 4);
                check("rd_strb", ram_strobe, 0);
                check("rd_wdata", ram_w_data, 0);
                sb_q.push_back(shadow[rreq_addr[9:4]]);
            end else begin
                check("idle_en", {ram_wr_en, ram_rd_en}, 0);
                check("idle_addr", ram_addr, 0);
            end
            if (rresp_valid && rresp_ready) begin
                if (sb_q.size() == 0) check("rresp_unexpected", 1, 0);
                else                  check("rresp_data", rresp_data, sb_q.pop_front());
            end
        end
    end

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [SW-1:0] s);
        bit got = 1'b0;
        wreq_valid = 1'b1;
        wreq_addr  = a;
        wreq_data  = d;
        wreq_strb  = s;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = wreq_ready;
        end
        check("wreq_handshake", got, 1);
        @(posedge clk);
        #1 wreq_valid = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        bit got = 1'b0;
        rreq_valid = 1'b1;
        rreq_addr  = a;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = rreq_ready;
        end
        check("rreq_handshake", got, 1);
        @(posedge clk);
        #1 rreq_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
        check("drain", sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        bit exp_rd;
        for (int i = 0; i < 64; i++) begin
            shadow[i]  = '0;
            ram_mem[i] = '0;
        end
        ram_r_data  = '0;
        rst_n       = 1'b0;
        rresp_ready = 1'b1;
        // Valids held high during reset: outputs must still be quiet.
        wreq_valid  = 1'b1;
        wreq_addr   = 32'h40;
        wreq_data   = 128'h1234;
        wreq_strb   = 16'hFFFF;
        rreq_valid  = 1'b1;
        rreq_addr   = 32'h80;
        #12;
        check("rst_rresp_valid", rresp_valid, 0);
        check("rst_wr_en", ram_wr_en, 0);
        check("rst_rd_en", ram_rd_en, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_strobe", ram_strobe, 0);
        check("rst_wdata", ram_w_data, 0);
        check("rst_wreq_ready", wreq_ready, 0);
        wreq_valid = 1'b0;
        rreq_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write then read of word 4, with response timing.
        wreq_valid = 1'b1;
        wreq_addr  = 32'h40;
        wreq_data  = 128'h0011_2233;
        wreq_strb  = 16'hFFFF;
        @(negedge clk);
        check("t1_wr_grant", wreq_ready, 1);
        check("t1_wr_addr", ram_addr, 4);
        @(posedge clk);
        #1 wreq_valid = 1'b0;
        rreq_valid = 1'b1;
        rreq_addr  = 32'h40;
        @(negedge clk);
        check("t1_rd_grant", rreq_ready, 1);
        check("t1_rd_addr", ram_addr, 4);
        @(posedge clk);
        #1 rreq_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t1_rresp_valid", rresp_valid, 1);
        check("t1_rresp_data", rresp_data, 128'h0011_2233);
        drain();

        // Partial strobe merge.
        do_write(32'h80, {DW{1'b1}}, 16'hFFFF);
        do_write(32'h80, 128'hAA, 16'h0001);
        do_read(32'h80);
        drain();

        // Contention; the preceding write leaves the write side as last granted.
        do_write(32'h100, 128'h5, 16'hFFFF);
        wreq_valid = 1'b1;
        wreq_addr  = 32'h100;
        wreq_data  = 128'h77;
        wreq_strb  = 16'hFFFF;
        rreq_valid = 1'b1;
        rreq_addr  = 32'h140;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
`ifdef RAM_ARB_WR_PRIO_EN
            exp_rd = 1'b0;
`else
            exp_rd = (i % 2 == 0);
`endif
            check("cont_rd", rreq_ready, exp_rd);
            check("cont_wr", wreq_ready, !exp_rd);
            @(posedge clk);
            #1;
        end
        wreq_valid = 1'b0;
        rreq_valid = 1'b0;
        drain();

        // Backpressure with a depth-2 response FIFO.
        rresp_ready = 1'b0;
        rreq_valid  = 1'b1;
        rreq_addr   = 32'h00;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rreq_ready) n++;
            @(posedge clk);
            #1;
        end
        check("bp_grants", n, 2);
        check("bp_rresp_valid", rresp_valid, 1);
        rresp_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rreq_ready) n++;
            @(posedge clk);
            #1 rresp_ready = 1'b0;
        end
        check("bp_more", n, 1);
        rreq_valid  = 1'b0;
        rresp_ready = 1'b1;
        drain();

        // Reset while a read is in flight.
        rreq_valid = 1'b1;
        rreq_addr  = 32'h40;
        @(negedge clk);
        check("mr_rd_grant", rreq_ready, 1);
        @(posedge clk);
        #1 rreq_valid = 1'b0;
        wreq_valid = 1'b1;
        wreq_addr  = 32'h40;
        wreq_data  = 128'hDEAD;
        wreq_strb  = 16'hFFFF;
        rst_n      = 1'b0;
        #1;
        check("mr_rresp_valid", rresp_valid, 0);
        check("mr_wr_en", ram_wr_en, 0);
        check("mr_rd_en", ram_rd_en, 0);
        check("mr_addr", ram_addr, 0);
        check("mr_strobe", ram_strobe, 0);
        check("mr_wdata", ram_w_data, 0);
        sb_q.delete();
        wreq_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("mr_no_stale", rresp_valid, 0);
        end
        @(posedge clk);
        #1;

        // Back-to-back reads return in grant order.
        do_write(32'h00, 128'hA0A0, 16'hFFFF);
        do_write(32'h10, 128'hA1A1, 16'hFFFF);
        do_write(32'h20, 128'hA2A2, 16'hFFFF);
        do_read(32'h00);
        do_read(32'h10);
        do_read(32'h20);
        drain();

        check("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/ram_req_arbiter.md
Name: ram_req_arbiter

Overview:
- Sequences and shares the single-port behavioural AXI memory model RAM between one write requester and one read requester.
- Arbitrates per cycle: round-robin by default, fixed write priority as a compile option.
- Converts byte addresses to word indices and drives the RAM's wr_en/rd_en/addr/strobe/w_data.
- Captures the 1-cycle-latency RAM read data into a response FIFO, so read responses can be back-pressured.
- Sits between the AXI slave channel logic and the RAM instance.

Parameters:
- DATA_WD, 128, RAM data width in bits.
- ADDR_WD, 32, byte address width on the request ports and on ram_addr.
- STRB_WD, DATA_WD/8, byte strobe width.
- RESP_DEPTH, 2, read response FIFO depth (power of two, ≥2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- wreq_valid  in  1  write request valid.
- wreq_ready  out  1  write request accepted.
- wreq_addr  in  ADDR_WD  write byte address.
- wreq_data  in  DATA_WD  write data.
- wreq_strb  in  STRB_WD  write byte strobes.
- rreq_valid  in  1  read request valid.
- rreq_ready  out  1  read request accepted.
- rreq_addr  in  ADDR_WD  read byte address.
- rresp_valid  out  1  read response valid.
- rresp_ready  in  1  read response consumed.
- rresp_data  out  DATA_WD  read response data.
- ram_wr_en  out  1  RAM write enable.
- ram_rd_en  out  1  RAM read enable.
- ram_addr  out  ADDR_WD  RAM word index.
- ram_strobe  out  STRB_WD  RAM byte strobes.
- ram_w_data  out  DATA_WD  RAM write data.
- ram_r_data  in  DATA_WD  RAM read data, valid one cycle after ram_rd_en.

Behaviour:
- Reset values (asynchronous, rst_n=0):
  - rresp_valid=0; FIFO count=0; rd_inflight=0; last_grant=WRITE.
  - All ram_* enables=0; ram_addr/strobe/w_data=0.
- Read eligibility: read may be granted only if (count + rd_inflight) < RESP_DEPTH. A pop in the same cycle is not credited.
- Arbitration (combinational, same cycle):
  - Only wreq_valid: grant write.
  - Only rreq_valid and read eligible: grant read.
  - Both valid and read eligible: grant the side opposite last_grant.
  - Both valid and read not eligible: grant write.
  - At most one grant per cycle.
- Handshake and RAM drive:
  - wreq_ready = write granted; rreq_ready = read granted.
  - Ready may depend on valid. Requesters hold valid and payload until ready.
  - RAM drives are combinational from the grant:
    - ram_wr_en = write grant; ram_rd_en = read grant.
    - ram_addr = granted address >> log2(DATA_WD/8), zero-extended.
    - ram_strobe = wreq_strb on write, 0 on read.
    - ram_w_data = wreq_data on write, 0 on read.
    - With no grant, every ram_* output is 0.
- last_grant updates on every grant. It holds when idle.
- Read pipeline:
  - rd_inflight <= read grant.
  - When rd_inflight=1, ram_r_data is pushed into the FIFO that cycle.
  - Best-case latency from read grant edge to rresp_valid is 1 cycle.
  - rresp_valid = count≠0. rresp_data = FIFO head. Pop on rresp_valid & rresp_ready.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Pointers wrap modulo RESP_DEPTH.
  - Overflow is impossible by construction. Assertion: a push never occurs with count=RESP_DEPTH and no pop.
- Ordering:
  - A write granted in cycle N and a read of the same word in cycle N+1 returns the new data.
  - Responses are returned in grant order.
- Reset mid-operation: in-flight read data is discarded, the FIFO is flushed, and no response is produced for it.

Optional Feature:
- Macro RAM_ARB_WR_PRIO_EN.
- Defined: whenever wreq_valid=1, write is granted. Read is granted only when wreq_valid=0 and read is eligible. last_grant is removed.
- Undefined: round-robin as above.

Test Plan:
- Write then read (DATA_WD=128): write addr 0x40, data 0x...0011_2233, strb 0xFFFF, then read 0x40.
  - Required: ram_addr=4 both times.
  - Required: rresp_data=0x...0011_2233 on the cycle after the read grant.
- Partial strobe: preload 0xFFFF.., write strb 0x0001 data 0x..AA, read back.
  - Required: low byte 0xAA, remaining bytes 0xFF.
- Contention: both valid continuously for 6 cycles, rresp_ready=1.
  - Required, default: grants R,W,R,W,R,W.
  - Required, RAM_ARB_WR_PRIO_EN: W×6 and rreq_ready=0.
- Backpressure: rresp_ready=0 with reads streaming (RESP_DEPTH=2).
  - Required: exactly 2 reads granted, then rreq_ready=0.
  - Required: after one pop, exactly one more read is granted.
- Reset mid-read: assert rst_n=0 in the cycle rd_inflight=1.
  - Required: rresp_valid=0 and all ram_* outputs 0 immediately (asynchronous).
  - Required: after release, no stale response appears.
- Back-to-back reads of 0x00, 0x10, 0x20 with rresp_ready=1.
  - Required: responses in the same order, one per cycle.
